// File: rtl/spram_byte_fifo_arbiter_if.sv
// Byte write/read stream handshakes and FIFO status shared by the SPRAM arbiter and its neighbours.
// The arbiter takes the slave side; the pixel packer / UART side takes the master side.
interface spram_byte_fifo_arbiter_if;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [15:0] level;
   logic        overflow;

   modport master (
      output wr_data, wr_valid, rd_ready,
      input  wr_ready, rd_data, rd_valid, level, overflow
   );

   modport slave (
      input  wr_data, wr_valid, rd_ready,
      output wr_ready, rd_data, rd_valid, level, overflow
   );
endinterface

// File: rtl/spram_byte_fifo_arbiter.sv
// Shares one single-port 16-bit SPRAM between a byte write stream and a byte read stream,
// presenting it as a byte-wide circular FIFO with write priority and a starvation guard.
module spram_byte_fifo_arbiter #(
   parameter int unsigned DEPTH_LOG2   = 15,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                     CLOCK,
   input  logic                     reset,
   spram_byte_fifo_arbiter_if.slave fifo,
   output logic [13:0]              spram_addr,
   output logic [15:0]              spram_datain,
   output logic [3:0]               spram_maskwren,
   output logic                     spram_wren,
   input  logic [15:0]              spram_dataout
);

   localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [15:0] DEPTH = 16'(32'd1 << DEPTH_LOG2);
   localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rstate_t;

   rstate_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [15:0]            level_q, level_d;
   logic [SW-1:0]          starve_q, starve_d;
   logic                   lane_q, lane_d;
   logic [7:0]             rd_data_q, rd_data_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   overflow_q, overflow_d;

   logic                   full, empty, force_read;
   logic                   wr_ready, wr_grant, rd_issue;
   logic [DEPTH_LOG2-1:0]  sel_ptr;

   always_comb begin
      full       = (level_q == DEPTH);
      empty      = (level_q == '0);
      force_read = (starve_q == SLIM);
      wr_ready   = !reset && !full && !force_read;
      wr_grant   = fifo.wr_valid && wr_ready;
      rd_issue   = (state_q == R_IDLE) && !empty && !wr_grant;
      sel_ptr    = wr_grant ? wr_ptr_q : rd_ptr_q;
   end

   // The SPRAM port is only ever driven by one side: a write grant owns it, otherwise rd_ptr does.
   assign spram_addr     = 14'(sel_ptr >> 1);
   assign spram_maskwren = sel_ptr[0] ? 4'b1100 : 4'b0011;
   assign spram_wren     = wr_grant;
   assign spram_datain   = {fifo.wr_data, fifo.wr_data};

   assign fifo.wr_ready  = wr_ready;
   assign fifo.rd_data   = rd_data_q;
   assign fifo.rd_valid  = rd_valid_q;
   assign fifo.level     = level_q;
   assign fifo.overflow  = overflow_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      starve_d   = starve_q;
      lane_d     = lane_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      overflow_d = overflow_q | (fifo.wr_valid && full);

      if (wr_grant) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         level_d  = level_q + 16'd1;
      end

      unique case (state_q)
         R_IDLE: begin
            if (rd_issue) begin
               rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
               level_d  = level_q - 16'd1;
               lane_d   = rd_ptr_q[0];
               state_d  = R_WAIT;
            end
            if (empty || rd_issue) begin
               starve_d = '0;
            end else if (wr_grant && !force_read) begin
               starve_d = starve_q + SW'(1);
            end
         end
         R_WAIT: begin
            state_d    = R_HOLD;
            rd_valid_d = 1'b1;
            rd_data_d  = lane_q ? spram_dataout[15:8] : spram_dataout[7:0];
         end
         R_HOLD: begin
            if (fifo.rd_ready) begin
               state_d    = R_IDLE;
               rd_valid_d = 1'b0;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (reset) begin
         state_q    <= R_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         starve_q   <= '0;
         lane_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         starve_q   <= starve_d;
         lane_q     <= lane_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_spram_byte_fifo_arbiter.sv
// Bench for the SPRAM byte FIFO arbiter: directed vector table, corner-case sequences and
// random traffic checked against a queue-based reference of the FIFO rules.
module tb_spram_byte_fifo_arbiter;

   localparam int LDEPTH = 16;
   localparam int LIM    = 4;

   logic        CLOCK;
   logic        rst;
   logic [13:0] spram_addr;
   logic [15:0] spram_datain;
   logic [3:0]  spram_maskwren;
   logic        spram_wren;
   logic [15:0] spram_dataout;
   logic [15:0] mem [0:16383];

   spram_byte_fifo_arbiter_if ifc ();

   spram_byte_fifo_arbiter #(
      .DEPTH_LOG2  (4),
      .STARVE_LIMIT(LIM)
   ) dut (
      .CLOCK         (CLOCK),
      .reset         (rst),
      .fifo          (ifc),
      .spram_addr    (spram_addr),
      .spram_datain  (spram_datain),
      .spram_maskwren(spram_maskwren),
      .spram_wren    (spram_wren),
      .spram_dataout (spram_dataout)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // SPRAM behaviour: nibble-masked write, registered read output that holds during writes.
   always @(posedge CLOCK) begin
      if (spram_wren) begin
         for (int n = 0; n < 4; n++)
            if (spram_maskwren[n]) mem[spram_addr][n*4 +: 4] <= spram_datain[n*4 +: 4];
      end else begin
         spram_dataout <= mem[spram_addr];
      end
   end

   int  n_checks = 0;
   int  n_pass   = 0;
   bit  chk_en   = 1'b1;

   // reference model state
   logic [7:0]  q[$];
   int          wcnt, rcnt, starve, phase;
   logic [7:0]  pend, m_rd_data;
   bit          m_ovf;
   bit          last_grant;

   // DUT samples taken mid-cycle by step()
   logic        s_rdy, s_wren, s_rdv;
   logic [13:0] s_addr;
   logic [3:0]  s_mask;
   logic [15:0] s_lvl;
   logic [7:0]  s_rdd;
   logic [7:0]  got[$];
   int          rdy_low_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input logic r, input logic wv, input logic [7:0] wd, input logic rr);
      bit grant, issue, full, rdy;
      int lvl, ptr;
      rst = r;
      ifc.wr_valid = wv;
      ifc.wr_data  = wd;
      ifc.rd_ready = rr;
      @(negedge CLOCK);
      lvl   = q.size();
      full  = (lvl == LDEPTH);
      rdy   = !r && !full && (starve < LIM);
      grant = wv && rdy;
      issue = (phase == 0) && (lvl > 0) && !grant;
      ptr   = grant ? (wcnt % LDEPTH) : (rcnt % LDEPTH);
      s_rdy = ifc.wr_ready; s_wren = spram_wren; s_addr = spram_addr; s_mask = spram_maskwren;
      s_lvl = ifc.level; s_rdv = ifc.rd_valid; s_rdd = ifc.rd_data;
      if (ifc.rd_valid && rr) got.push_back(ifc.rd_data);
      if (!ifc.wr_ready) rdy_low_cnt++;
      if (chk_en) begin
         chk("wr_ready", 32'(ifc.wr_ready), 32'(rdy));
         chk("spram_wren", 32'(spram_wren), 32'(grant));
         chk("spram_addr", 32'(spram_addr), 32'(ptr / 2));
         chk("spram_mask", 32'(spram_maskwren), (ptr % 2) ? 32'hC : 32'h3);
         if (grant) chk("spram_datain", 32'(spram_datain), 32'({wd, wd}));
         chk("level", 32'(ifc.level), 32'(lvl));
         chk("rd_valid", 32'(ifc.rd_valid), 32'(phase == 2));
         chk("rd_data", 32'(ifc.rd_data), 32'(m_rd_data));
         chk("overflow", 32'(ifc.overflow), 32'(m_ovf));
      end
      last_grant = grant;
      @(posedge CLOCK);
      if (r) begin
         q.delete(); wcnt = 0; rcnt = 0; starve = 0; phase = 0; m_rd_data = 8'h00; m_ovf = 1'b0;
      end else begin
         if (phase == 0) begin
            if (lvl == 0 || issue) starve = 0;
            else if (grant && starve < LIM) starve++;
         end
         if (wv && full) m_ovf = 1'b1;
         if (grant) begin q.push_back(wd); wcnt++; end
         if (issue) begin pend = q.pop_front(); rcnt++; phase = 1; end
         else if (phase == 1) begin phase = 2; m_rd_data = pend; end
         else if (phase == 2 && rr) phase = 0;
      end
      #1;
   endtask

   typedef struct {
      logic r, wv; logic [7:0] wd; logic rr;
      logic e_rdy, e_wren; logic [13:0] e_addr; logic [3:0] e_mask;
      logic [15:0] e_lvl; logic e_rdv; logic [7:0] e_rdd;
   } vec_t;

   vec_t vecs[19];

   initial begin
      vecs = '{
         '{1'b1,1'b1,8'hA1,1'b0, 1'b0,1'b0,14'd0,4'h3,16'd0,1'b0,8'h00},
         '{1'b1,1'b1,8'hA1,1'b0, 1'b0,1'b0,14'd0,4'h3,16'd0,1'b0,8'h00},
         '{1'b0,1'b1,8'hA1,1'b0, 1'b1,1'b1,14'd0,4'h3,16'd0,1'b0,8'h00},
         '{1'b0,1'b1,8'hA2,1'b0, 1'b1,1'b1,14'd0,4'hC,16'd1,1'b0,8'h00},
         '{1'b0,1'b1,8'hA3,1'b0, 1'b1,1'b1,14'd1,4'h3,16'd2,1'b0,8'h00},
         '{1'b0,1'b1,8'hA4,1'b0, 1'b1,1'b1,14'd1,4'hC,16'd3,1'b0,8'h00},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd0,4'h3,16'd4,1'b0,8'h00},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd0,4'hC,16'd3,1'b0,8'h00},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd0,4'hC,16'd3,1'b1,8'hA1},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd0,4'hC,16'd3,1'b0,8'hA1},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd1,4'h3,16'd2,1'b0,8'hA1},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd1,4'h3,16'd2,1'b1,8'hA2},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd1,4'h3,16'd2,1'b0,8'hA2},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd1,4'hC,16'd1,1'b0,8'hA2},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd1,4'hC,16'd1,1'b1,8'hA3},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd1,4'hC,16'd1,1'b0,8'hA3},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd2,4'h3,16'd0,1'b0,8'hA3},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd2,4'h3,16'd0,1'b1,8'hA4},
         '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,14'd2,4'h3,16'd0,1'b0,8'hA4}
      };

      rst = 1'b1; ifc.wr_valid = 1'b0; ifc.wr_data = 8'h00; ifc.rd_ready = 1'b0;
      wcnt = 0; rcnt = 0; starve = 0; phase = 0; m_rd_data = 8'h00; m_ovf = 1'b0;
      rdy_low_cnt = 0;

      // first reset edge: state undefined before it, so nothing is compared
      chk_en = 1'b0;
      step(1'b1, 1'b1, 8'hA1, 1'b0);
      chk_en = 1'b1;

      // reset hold, ordering and byte lanes
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].wv, vecs[i].wd, vecs[i].rr);
         chk($sformatf("vec%0d_wr_ready", i), 32'(s_rdy), 32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d_wren", i), 32'(s_wren), 32'(vecs[i].e_wren));
         chk($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(vecs[i].e_addr));
         chk($sformatf("vec%0d_mask", i), 32'(s_mask), 32'(vecs[i].e_mask));
         chk($sformatf("vec%0d_level", i), 32'(s_lvl), 32'(vecs[i].e_lvl));
         chk($sformatf("vec%0d_rd_valid", i), 32'(s_rdv), 32'(vecs[i].e_rdv));
         chk($sformatf("vec%0d_rd_data", i), 32'(s_rdd), 32'(vecs[i].e_rdd));
      end

      // full and overflow with the consumer stalled
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      chk("full_level", 32'(ifc.level), 32'd16);
      chk("full_wr_ready", 32'(ifc.wr_ready), 32'd0);
      chk("full_overflow", 32'(ifc.overflow), 32'd1);
      step(1'b0, 1'b1, 8'h55, 1'b1);
      step(1'b0, 1'b1, 8'h55, 1'b0);
      chk("reopen_level", 32'(ifc.level), 32'd15);
      chk("reopen_wr_ready", 32'(ifc.wr_ready), 32'd1);

      // wrap: 40 bytes through a 16-byte FIFO
      step(1'b1, 1'b0, 8'h00, 1'b0);
      got.delete();
      begin
         int nxt, cyc;
         nxt = 0; cyc = 0;
         while (got.size() < 40 && cyc < 2000) begin
            step(1'b0, nxt < 40, 8'(nxt), 1'b1);
            if (last_grant) nxt++;
            cyc++;
         end
         if (cyc >= 2000) chk("wrap_timeout", 32'(cyc), 32'd0);
      end
      chk("wrap_count", 32'(got.size()), 32'd40);
      foreach (got[i]) chk($sformatf("wrap_byte%0d", i), 32'(got[i]), 32'(i));

      // starvation: continuous writes, reads forced by the starve counter
      step(1'b1, 1'b0, 8'h00, 1'b0);
      rdy_low_cnt = 0;
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);
      chk("starve_forced_cycles", 32'(rdy_low_cnt), 32'd3);
      chk("starve_overflow", 32'(ifc.overflow), 32'd0);

      // reset during R_WAIT drops the in-flight byte; next read sees the new byte
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h5A, 1'b0);
      step(1'b0, 1'b1, 8'h6B, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk("rstmid_rd_valid", 32'(ifc.rd_valid), 32'd0);
      chk("rstmid_level", 32'(ifc.level), 32'd0);
      step(1'b0, 1'b1, 8'hC3, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("rstmid_new_valid", 32'(ifc.rd_valid), 32'd1);
      chk("rstmid_new_data", 32'(ifc.rd_data), 32'hC3);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
